// File: rtl/priority_req_ctrl.sv
// priority_req_ctrl
// Turns rising edges on four request lines into a sticky pending set.
// Grants one pending request at a time, highest index first, and holds
// each grant until the consumer acknowledges it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant outstanding; valid=0; grants when en=1 and pending!=0
// GRANT | grant outstanding; valid=1; code held until ack
module priority_req_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       valid,
    output logic [1:0] code,
    output logic [3:0] pending,
    output logic       ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic [3:0] pending_q, pending_d;
    logic       ovf_q, ovf_d;
    logic [3:0] req_q;

    logic [3:0] rise;
    logic [3:0] clr;
    logic       grant_done;

    // Fixed priority: bit 3 wins. Only called with a non-zero vector.
    function automatic logic [1:0] hi_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        else           idx = 2'd0;
        return idx;
    endfunction

    // Edge detect, service clear, and pending / overflow next-state.
    // A new rising edge on the bit being cleared wins, so the request is not lost.
    always_comb begin
        rise       = req & ~req_q;
        grant_done = (state_q == GRANT) && ack;
        clr        = grant_done ? (4'b0001 << code_q) : 4'b0000;
        pending_d  = (pending_q & ~clr) | rise;
        ovf_d      = ovf_q | (|(rise & pending_q & ~clr));
    end

    // Grant FSM: next state, held code and valid.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (en && (pending_q != 4'b0000)) begin
                    state_d = GRANT;
                    code_d  = hi_idx(pending_q);
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                valid_d = 1'b1;
                if (ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            code_q    <= 2'd0;
            pending_q <= 4'b0000;
            ovf_q     <= 1'b0;
            req_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            req_q     <= req;
        end
    end

    assign valid   = valid_q;
    assign code    = code_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/priority_req_ctrl.md
PRIORITY_REQ_CTRL -- requirements
Module: priority_req_ctrl

Interface
REQ-001 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 Port en, input, 1 bit: grant enable; when 0, no new grant starts.
REQ-004 Port req, input, 4 bits: request lines; bit 3 is the highest priority and bit 0 the lowest.
REQ-005 Port ack, input, 1 bit: the consumer accepts the current grant.
REQ-006 Port valid, output, 1 bit: grant valid; code is meaningful only while valid is 1.
REQ-007 Port code, output, 2 bits: index of the granted request.
REQ-008 Port pending, output, 4 bits: latched requests not yet serviced.
REQ-009 Port ovf, output, 1 bit: sticky flag for a lost request.

Function
REQ-010 The block SHALL register req every cycle into req_d; rise = req & ~req_d.
REQ-011 At each clock edge, pending[i] SHALL be set if rise[i]=1.
REQ-012 At each clock edge, pending[i] SHALL be cleared if bit i is being serviced this cycle (see REQ-016) and rise[i]=0.
REQ-013 If rise[i]=1 in the same cycle that bit i is cleared, the set SHALL win, and pending[i] is 1 after the edge.
REQ-014 ovf SHALL be set to 1 when rise[i]=1 while pending[i]=1 and bit i is not being cleared that cycle; ovf is then held until reset.
REQ-015 The FSM SHALL have two states, IDLE and GRANT.
  - IDLE: valid=0.
  - IDLE -> GRANT when en=1 and pending!=0, using the pending value before this edge.
  - On that transition, code <= index of the highest set bit of pending and valid <= 1.
REQ-016 In GRANT, valid=1 and code is held stable.
  - ack=1 -> IDLE; pending[code] is cleared at the same edge and valid <= 0.
  - ack=0 -> stay in GRANT.
REQ-017 In GRANT, en=0 SHALL NOT abort the grant; the grant completes only on ack.
REQ-018 Requests arriving during GRANT SHALL only latch into pending; the held code SHALL NOT be pre-empted, even by a higher priority.
REQ-019 After each ack, the FSM SHALL spend at least one cycle in IDLE, so valid is low for at least one cycle between grants.
REQ-020 Minimum latency from req rising before edge N:
  - pending set at edge N;
  - valid=1 after edge N+1.
REQ-021 ack while in IDLE SHALL be ignored.
REQ-022 Back-to-back service: every pending bit SHALL eventually be granted in descending priority order while en=1 and the consumer acks.
REQ-023 A request line held high SHALL produce exactly one pending set; a new rising edge is required to request again.

Reset
REQ-024 While rst=1, regardless of clk, the following SHALL be forced: state=IDLE, valid=0, code=0, pending=0, ovf=0, req_d=0.
REQ-025 A req bit already high at reset release SHALL count as a rising edge at the first clock edge after release.
REQ-026 Reset asserted mid-GRANT SHALL drop valid immediately (asynchronously) and discard all pending requests.

Verification
REQ-027 The bench SHALL cover each scenario below.
  - Single request: en=1, req=0100 for one cycle -> pending=0100 after edge N; valid=1, code=2 after N+1; ack=1 for one cycle -> valid=0, pending=0000.
  - Priority: req=1011 rising together, en=1, ack one cycle after each grant -> grant sequence is code 3, 1, 0 with a valid-low gap between grants; pending ends at 0000.
  - No pre-emption: in GRANT with code=0, req[3] rises -> code stays 0 until ack; the next grant is code=3.
  - Enable gating: en=0 with pending=0010 -> valid stays 0 indefinitely; en=1 -> valid=1, code=1 after one edge. en dropped during GRANT -> grant held until ack.
  - Overflow and collision:
    - req[1] pulses twice while pending[1]=1 and no ack -> ovf=1, held until rst.
    - req[1] rising on the same edge as the ack for code=1 -> pending[1]=1 and ovf=0.
  - Reset: rst pulsed high mid-cycle while valid=1 and pending=1100 -> valid, code, pending and ovf read 0 before the next clk edge. req=0001 held across release -> pending=0001 after the first edge.
